// File: rtl/chan_512_packet_fir_coeff_seq.sv
// chan_512_packet_fir_coeff_seq: turns toggle-qualified software register commands into
// shadow-bank FIR coefficient writes, bulk clears and sync-aligned bank swaps.
module chan_512_packet_fir_coeff_seq #(
    parameter int N_TAPS = 32,
    parameter int ADDR_W = 5,
    parameter int COEF_W = 16
) (
    input  logic              user_clk,
    input  logic              user_rst,
    input  logic [31:0]       reg_data,
    input  logic              sync_in,
    output logic              coef_we,
    output logic [ADDR_W-1:0] coef_addr,
    output logic [COEF_W-1:0] coef_data,
    output logic              coef_bank_sel,
    output logic              active_bank,
    output logic              swap_pulse,
    output logic              busy,
    output logic              err,
    output logic [15:0]       cmd_count
);
    typedef enum logic [2:0] {IDLE, WR, CLR, ARMED, SWAP} state_t;
    localparam logic [1:0] OP_WR = 2'd1, OP_COMMIT = 2'd2, OP_CLR = 2'd3;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_TAPS - 1);
    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    state_t state, next_state;
    logic [31:0] r_data;
    logic last_toggle, new_cmd, addr_bad, accept;
    logic [1:0] op;
    logic we_n, bank_n, swap_n, busy_n, err_n;
    logic [ADDR_W-1:0] addr_n;
    logic [COEF_W-1:0] data_n;
    logic [15:0] cnt_n;

    assign op       = r_data[30:29];
    assign new_cmd  = r_data[31] ^ last_toggle;
    assign addr_bad = |(r_data[28:16] >> ADDR_W);
    // Commands arriving while busy are dropped, as are writes beyond the tap range.
    assign accept   = new_cmd && state == IDLE && !(op == OP_WR && addr_bad);

    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            state       <= IDLE;
            r_data      <= '0;
            last_toggle <= 1'b0;
        end else begin
            state       <= next_state;
            r_data      <= reg_data;
            last_toggle <= r_data[31];
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  next_state = !accept ? IDLE :
                                op == OP_WR ? WR :
                                op == OP_COMMIT ? ARMED :
                                op == OP_CLR ? CLR : IDLE;
            WR:    next_state = IDLE;
            CLR:   next_state = coef_addr == LAST ? IDLE : CLR;
            ARMED: next_state = sync_in ? SWAP : ARMED;
            SWAP:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        we_n   = next_state == WR || next_state == CLR;
        addr_n = (state == IDLE && accept) ? (op == OP_WR ? r_data[16 +: ADDR_W] : '0) :
                 state == CLR ? coef_addr + ONE : coef_addr;
        data_n = (state == IDLE && accept && op == OP_WR) ? r_data[COEF_W-1:0] :
                 next_state == CLR ? '0 : coef_data;
        swap_n = state == ARMED && sync_in;
        bank_n = swap_n ? ~active_bank : active_bank;
        busy_n = next_state != IDLE;
        err_n  = err | (new_cmd & ~accept);
        cnt_n  = cmd_count + {15'd0, accept};
    end

    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            coef_we       <= 1'b0;
            coef_addr     <= '0;
            coef_data     <= '0;
            active_bank   <= 1'b0;
            coef_bank_sel <= 1'b1;
            swap_pulse    <= 1'b0;
            busy          <= 1'b0;
            err           <= 1'b0;
            cmd_count     <= '0;
        end else begin
            coef_we       <= we_n;
            coef_addr     <= addr_n;
            coef_data     <= data_n;
            active_bank   <= bank_n;
            coef_bank_sel <= ~bank_n;
            swap_pulse    <= swap_n;
            busy          <= busy_n;
            err           <= err_n;
            cmd_count     <= cnt_n;
        end
    end
endmodule

// File: tb/tb_chan_512_packet_fir_coeff_seq.sv
// tb_chan_512_packet_fir_coeff_seq: directed commands with a queued scoreboard for coef writes and swaps.
module tb_chan_512_packet_fir_coeff_seq;
    logic user_clk = 1'b0, user_rst = 1'b1, sync_in = 1'b0;
    logic [31:0] reg_data = '0;
    logic coef_we, coef_bank_sel, active_bank, swap_pulse, busy, err;
    logic [4:0] coef_addr;
    logic [15:0] coef_data, cmd_count;

    chan_512_packet_fir_coeff_seq dut (
        .user_clk(user_clk), .user_rst(user_rst), .reg_data(reg_data), .sync_in(sync_in),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .coef_bank_sel(coef_bank_sel), .active_bank(active_bank), .swap_pulse(swap_pulse),
        .busy(busy), .err(err), .cmd_count(cmd_count)
    );

    always #5 user_clk = ~user_clk;

    typedef struct {int c; int a; int d; int b;} ev_t;
    ev_t wq[$];
    ev_t sq[$];
    int cyc = 0, total = 0, bad = 0;
    logic tg = 1'b0;

    always @(posedge user_clk) cyc <= cyc + 1;

    always @(negedge user_clk) begin
        ev_t e;
        if (!user_rst && coef_we) begin
            total++;
            if (wq.size() == 0) begin
                bad++;
                $display("FAIL coef_we unexpected: cyc=%0d addr=%0d data=%h", cyc, coef_addr, coef_data);
            end else begin
                e = wq.pop_front();
                if (e.c != cyc || e.a != int'(coef_addr) || e.d != int'(coef_data) || e.b != int'(coef_bank_sel)) begin
                    bad++;
                    $display("FAIL coef_write: got cyc=%0d addr=%0d data=%h sel=%0d, want cyc=%0d addr=%0d data=%h sel=%0d",
                             cyc, coef_addr, coef_data, coef_bank_sel, e.c, e.a, e.d, e.b);
                end
            end
        end
        if (!user_rst && swap_pulse) begin
            total++;
            if (sq.size() == 0) begin
                bad++;
                $display("FAIL swap_pulse unexpected: cyc=%0d bank=%0d", cyc, active_bank);
            end else begin
                e = sq.pop_front();
                if (e.c != cyc || e.b != int'(active_bank)) begin
                    bad++;
                    $display("FAIL swap: got cyc=%0d bank=%0d, want cyc=%0d bank=%0d", cyc, active_bank, e.c, e.b);
                end
            end
        end
    end

    task automatic tick(input int k);
        repeat (k) @(posedge user_clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [12:0] a, input logic [15:0] d, output int n);
        tg = ~tg;
        reg_data = {tg, op, a, d};
        n = cyc;
    endtask

    // COMMIT with an ignored sync in the detection cycle, then a real sync 100 cycles on.
    task automatic commit_sync(input int exp_bank);
        int n;
        send(2'd2, 13'd0, 16'd0, n);
        tick(1);
        sync_in = 1'b1;
        tick(1);
        sync_in = 1'b0;
        check("commit_busy_rise", int'(busy), 1);
        tick(n + 100 - cyc);
        sync_in = 1'b1;
        sq.push_back('{cyc + 1, 0, 0, exp_bank});
        tick(1);
        sync_in = 1'b0;
        check("swap_active_bank", int'(active_bank), exp_bank);
        check("swap_bank_sel", int'(coef_bank_sel), 1 - exp_bank);
        check("swap_busy_held", int'(busy), 1);
        tick(1);
        check("swap_busy_fall", int'(busy), 0);
    endtask

    initial begin
        int n, m;
        tick(3);
        check("rst_we", int'(coef_we), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_bank", int'(active_bank), 0);
        check("rst_sel", int'(coef_bank_sel), 1);
        check("rst_cnt", int'(cmd_count), 0);
        user_rst = 1'b0;
        tick(2);

        for (int i = 0; i < 32; i++) begin
            send(2'd1, 13'(i), 16'(16'h1000 + i), n);
            wq.push_back('{n + 2, i, 16'h1000 + i, 1});
            tick(2);
        end
        tick(3);
        check("sweep_cnt", int'(cmd_count), 32);
        check("sweep_err", int'(err), 0);

        commit_sync(1);
        check("commit1_cnt", int'(cmd_count), 33);
        commit_sync(0);
        check("commit2_cnt", int'(cmd_count), 34);

        send(2'd1, 13'h20, 16'h5555, n);
        tick(3);
        check("badaddr_err", int'(err), 1);
        check("badaddr_cnt", int'(cmd_count), 34);

        send(2'd3, 13'd0, 16'hFFFF, n);
        for (int i = 0; i < 32; i++) wq.push_back('{n + 2 + i, i, 0, 1});
        tick(2);
        send(2'd1, 13'd3, 16'h7777, m);
        tick(n + 33 - cyc);
        check("clr_busy_last", int'(busy), 1);
        tick(1);
        check("clr_busy_fall", int'(busy), 0);
        check("clr_cnt", int'(cmd_count), 35);
        check("clr_err", int'(err), 1);

        commit_sync(1);
        send(2'd2, 13'd0, 16'd0, n);
        tick(4);
        check("armed_busy", int'(busy), 1);
        user_rst = 1'b1;
        reg_data = '0;
        tg = 1'b0;
        tick(1);
        sync_in = 1'b1;
        tick(1);
        sync_in = 1'b0;
        user_rst = 1'b0;
        tick(2);
        sync_in = 1'b1;
        tick(1);
        sync_in = 1'b0;
        tick(2);
        check("post_rst_bank", int'(active_bank), 0);
        check("post_rst_busy", int'(busy), 0);
        check("post_rst_err", int'(err), 0);
        check("post_rst_cnt", int'(cmd_count), 0);
        check("post_rst_we", int'(coef_we), 0);
        check("post_rst_sel", int'(coef_bank_sel), 1);

        send(2'd1, 13'd5, 16'hBEEF, n);
        wq.push_back('{n + 2, 5, 16'hBEEF, 1});
        tick(4);
        check("post_rst_write_cnt", int'(cmd_count), 1);
        check("writes_outstanding", wq.size(), 0);
        check("swaps_outstanding", sq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
